// File: rtl/au_rr_arb_pkg.sv
// au_rr_arb_pkg: shared sizing helpers for the AU round-robin arbiter.
//   clogb2(n) - ceil(log2(n)), 0 for n <= 1
//   idx_w(n)  - encoded index width, at least 1 bit
package au_rr_arb_pkg;

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return (clogb2(n) > 1) ? clogb2(n) : 1;
    endfunction

endpackage

// File: rtl/au_rr_arb_encode.sv
// au_rr_arb_encode: one-hot to binary index encoder.
//   i_onehot - one-hot (or all-zero) vector, WIDTH bits
//   o_idx    - binary index of the set bit, 0 when no bit is set
module au_rr_arb_encode
    import au_rr_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IW = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] i_onehot,
    output logic [IW-1:0]    o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < WIDTH; i++) o_idx = o_idx | (i_onehot[i] ? IW'(i) : '0);
    end

endmodule

// File: rtl/au_rr_arb.sv
// au_rr_arb: round-robin arbiter with a registered, sticky one-hot grant and valid/ready handshake.
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   req     - request vector, any number of bits set
//   vld     - grant valid
//   rdy     - downstream accepts the current grant
//   gnt     - registered one-hot grant, zero when vld is low
//   gnt_idx - binary index of the granted bit, zero when vld is low
module au_rr_arb
    import au_rr_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IW = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    output logic             vld,
    input  logic             rdy,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_gnt;
    logic             r_vld;

    logic [IW-1:0]    w_idx_inc;
    logic [IW-1:0]    w_base;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_masked;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_win;
    logic [IW-1:0]    w_win_idx;
    logic             w_any;
    logic             w_adv;

    // Pointer after a handshake on the current grant, wrapping for any WIDTH.
    assign w_idx_inc = (r_idx == IW'(WIDTH - 1)) ? '0 : r_idx + IW'(1);
    // A handshake moves the pointer this same edge, so the next winner must see it already.
    assign w_base    = (r_state == S_HOLD) ? w_idx_inc : r_ptr;
    assign w_mask    = ~((WIDTH'(1) << w_base) - WIDTH'(1));
    assign w_masked  = req & w_mask;
    assign w_any     = |req;
    assign w_sel     = (|w_masked) ? w_masked : req;
    // Isolate the lowest set bit.
    assign w_win     = w_sel & (~w_sel + WIDTH'(1));
    assign w_adv     = (r_state == S_IDLE) || rdy;

    au_rr_arb_encode #(.WIDTH(WIDTH)) u_enc (
        .i_onehot(w_win),
        .o_idx   (w_win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_vld   <= 1'b0;
        end else if (w_adv) begin
            if (r_state == S_HOLD) r_ptr <= w_idx_inc;
            r_state <= w_any ? S_HOLD : S_IDLE;
            r_vld   <= w_any;
            r_gnt   <= w_win;
            r_idx   <= w_win_idx;
        end
    end

    assign vld     = r_vld;
    assign gnt     = r_gnt;
    assign gnt_idx = r_idx;

endmodule

// File: tb/tb_au_rr_arb.sv
// tb_au_rr_arb: self-checking bench for au_rr_arb at WIDTH 8, 5 and 1.
module tb_au_rr_arb;

    typedef struct {
        int ptr;
        bit v;
        int idx;
    } mstate_t;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       vld;
        int         idx;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] req8, gnt8;
    logic [2:0] idx8;
    logic       vld8, rdy8;
    logic [4:0] req5, gnt5;
    logic [2:0] idx5;
    logic       vld5, rdy5;
    logic [0:0] req1, gnt1, idx1;
    logic       vld1, rdy1;

    int n_cmp;
    int n_err;
    mstate_t m8, m5, m1;
    vec_t tbl[21];

    au_rr_arb #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .req(req8), .vld(vld8), .rdy(rdy8), .gnt(gnt8), .gnt_idx(idx8));
    au_rr_arb #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .req(req5), .vld(vld5), .rdy(rdy5), .gnt(gnt5), .gnt_idx(idx5));
    au_rr_arb #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .req(req1), .vld(vld1), .rdy(rdy1), .gnt(gnt1), .gnt_idx(idx1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: rotate the scan start, pick the first requester found.
    function automatic mstate_t mnext(mstate_t s, int n, logic [7:0] r, bit rd);
        mstate_t o;
        int base;
        bit found;
        o = s;
        if (s.v && !rd) return o;
        base = s.v ? (s.idx + 1) % n : s.ptr;
        o.ptr = base;
        o.v = 0;
        o.idx = 0;
        found = 0;
        for (int k = 0; k < n; k++) begin
            if (!found && r[(base + k) % n]) begin
                found = 1;
                o.v = 1;
                o.idx = (base + k) % n;
            end
        end
        return o;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mreset();
        m8 = '{0, 0, 0};
        m5 = '{0, 0, 0};
        m1 = '{0, 0, 0};
    endtask

    task automatic check_model();
        chk("m8_vld", int'(vld8), int'(m8.v));
        chk("m8_idx", int'(idx8), m8.idx);
        chk("m8_gnt", int'(gnt8), m8.v ? (1 << m8.idx) : 0);
        chk("m5_vld", int'(vld5), int'(m5.v));
        chk("m5_idx", int'(idx5), m5.idx);
        chk("m5_gnt", int'(gnt5), m5.v ? (1 << m5.idx) : 0);
        chk("m1_vld", int'(vld1), int'(m1.v));
        chk("m1_idx", int'(idx1), m1.idx);
        chk("m1_gnt", int'(gnt1), m1.v ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) mreset();
        else begin
            m8 = mnext(m8, 8, req8, rdy8);
            m5 = mnext(m5, 5, {3'b0, req5}, rdy5);
            m1 = mnext(m1, 1, {7'b0, req1}, rdy1);
        end
        #1;
        check_model();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mreset();
        rst = 1'b1;
        req8 = '0; rdy8 = 1'b0;
        req5 = '0; rdy5 = 1'b0;
        req1 = '0; rdy1 = 1'b0;
        #1;
        chk("rst_vld8", int'(vld8), 0);
        chk("rst_gnt8", int'(gnt8), 0);
        chk("rst_idx8", int'(idx8), 0);
        step();
        step();
        rst = 1'b0;

        // Two requesters alternate, then full rotation with wrap, then sticky grant.
        tbl[0]  = '{8'h81, 1'b1, 1'b1, 0};
        tbl[1]  = '{8'h81, 1'b1, 1'b1, 7};
        tbl[2]  = '{8'h81, 1'b1, 1'b1, 0};
        tbl[3]  = '{8'h81, 1'b1, 1'b1, 7};
        for (int i = 0; i < 9; i++) tbl[4 + i] = '{8'hFF, 1'b1, 1'b1, i % 8};
        tbl[13] = '{8'h08, 1'b1, 1'b1, 3};
        for (int i = 0; i < 4; i++) tbl[14 + i] = '{8'h01, 1'b0, 1'b1, 3};
        tbl[18] = '{8'h01, 1'b1, 1'b1, 0};
        tbl[19] = '{8'h00, 1'b1, 1'b0, 0};
        tbl[20] = '{8'h00, 1'b0, 1'b0, 0};
        for (int i = 0; i < 21; i++) begin
            req8 = tbl[i].req;
            rdy8 = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_vld", i), int'(vld8), int'(tbl[i].vld));
            chk($sformatf("tbl%0d_idx", i), int'(idx8), tbl[i].idx);
            chk($sformatf("tbl%0d_gnt", i), int'(gnt8), tbl[i].vld ? (1 << tbl[i].idx) : 0);
        end

        // Asynchronous reset mid-HOLD, between edges.
        req8 = 8'hFF;
        rdy8 = 1'b0;
        step();
        chk("pre_rst_vld", int'(vld8), 1);
        chk("pre_rst_idx", int'(idx8), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_vld", int'(vld8), 0);
        chk("async_gnt", int'(gnt8), 0);
        chk("async_idx", int'(idx8), 0);
        #1 rst = 1'b0;
        mreset();
        step();
        chk("post_rst_vld", int'(vld8), 1);
        chk("post_rst_idx", int'(idx8), 0);
        req8 = '0;
        rdy8 = 1'b1;
        step();

        // WIDTH=5 wrap from index 4 back to 0.
        req5 = 5'b10000;
        rdy5 = 1'b1;
        step();
        chk("w5_idx4", int'(idx5), 4);
        req5 = 5'b00001;
        step();
        chk("w5_idx0", int'(idx5), 0);
        chk("w5_vld", int'(vld5), 1);
        req5 = '0;
        step();
        chk("w5_idle", int'(vld5), 0);

        // WIDTH=1: vld follows req one cycle later.
        rdy1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req1 = 1'(i % 2 == 0);
            step();
            chk($sformatf("w1_vld%0d", i), int'(vld1), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("w1_idx%0d", i), int'(idx1), 0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            req8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rdy8 = ($urandom_range(0, 3) != 0);
            req5 = 5'($urandom);
            rdy5 = $urandom_range(0, 1) == 1;
            req1 = 1'($urandom);
            rdy1 = $urandom_range(0, 2) != 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/au_rr_arb.md
AU_RR_ARB -- requirements
Module: AU_rr_arb

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of requesters (>= 1).
REQ-002 SHALL have derived constant IW = max(ceil(log2(WIDTH)), 1), the encoded index width.
REQ-003 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: req  input  WIDTH  request vector, any number of bits set.
REQ-006 SHALL have port: vld  output  1  grant valid.
REQ-007 SHALL have port: rdy  input  1  downstream accepts grant.
REQ-008 SHALL have port: gnt  output  WIDTH  registered one-hot grant.
REQ-009 SHALL have port: gnt_idx  output  IW  binary index of the set bit of gnt.
REQ-010 SHALL use one clock, with reset asynchronous and active-high.

Function
REQ-011 SHALL implement a 2-state FSM: IDLE (vld=0), HOLD (vld=1).
REQ-012 SHALL hold a round-robin pointer ptr (IW bits, range 0..WIDTH-1).
REQ-013 SHALL select as winner the first set bit of req scanning ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1.
REQ-014 SHALL, in IDLE with req != 0 at edge t, register gnt/gnt_idx of the winner and assert vld from cycle t+1 (latency 1); with req == 0, stay IDLE.
REQ-015 SHALL keep gnt, gnt_idx and vld stable in HOLD until the cycle where vld && rdy; grant is sticky, so req deassertion in HOLD is ignored.
REQ-016 SHALL, on handshake, set ptr <= gnt_idx+1, wrapping WIDTH-1 -> 0 (also for non-power-of-2 WIDTH).
REQ-017 SHALL, on handshake with req != 0 in the same cycle, compute the next winner from the updated ptr value and stay in HOLD with new grant next cycle (back-to-back, 1 grant/cycle).
REQ-018 SHALL, on handshake with req == 0, go to IDLE and clear gnt, gnt_idx, vld.
REQ-019 SHALL drive gnt = 0 and gnt_idx = 0 whenever vld = 0.
REQ-020 SHALL, for WIDTH = 1, grant bit 0 whenever req[0], with gnt_idx constant 0 and ptr constant 0.
REQ-021 SHALL use the current req to resolve rdy and req changes in the same cycle; rdy is ignored in IDLE.
REQ-022 SHALL guarantee no starvation: a continuously asserted request is granted within WIDTH handshakes.

Reset
REQ-023 SHALL, on rst assertion, immediately force: state IDLE, ptr 0, vld 0, gnt 0, gnt_idx 0, regardless of clk.
REQ-024 SHALL, on rst asserted mid-HOLD, drop the pending grant without handshake; first arbitration after release starts from ptr 0.
REQ-025 SHALL arbitrate at the first rising clk edge after rst deasserts.

Structure
REQ-026 SHALL take the clogb2 helper from the shared function include used by other AU blocks; FSM state encodings remain local constants.
REQ-027 SHALL derive gnt_idx from the next-grant one-hot vector through one AU_encode instance (WIDTH = WIDTH), registered alongside gnt.
REQ-028 SHALL implement masked priority selection (req masked at/above ptr, else unmasked req) as combinational logic within this module.

Verification
REQ-029 SHALL test: WIDTH=8, after reset req=8'b1000_0001 held, rdy=1 -> grants idx 0, 7, 0, 7 on consecutive cycles, vld never drops.
REQ-030 SHALL test: WIDTH=8, req=8'hFF, rdy=1 for 9 cycles -> gnt_idx 0,1,...,7,0; ptr wraps 7->0.
REQ-031 SHALL test: WIDTH=8, grant idx 3 issued, rdy=0 for 4 cycles while req changes to 8'h01 -> gnt=8'h08, gnt_idx=3 stable; on rdy=1 next grant idx 0.
REQ-032 SHALL test: WIDTH=5, req=5'b10000 then 5'b00001 after handshake -> idx 4, then ptr=0, idx 0; gnt_idx width 3.
REQ-033 SHALL test: WIDTH=8, rst pulsed asynchronously between edges during HOLD -> vld, gnt, gnt_idx go 0 before next edge; next grant for req=8'hFF is idx 0.
REQ-034 SHALL test: WIDTH=1, req toggling with rdy=1 -> vld follows req one cycle later, gnt_idx always 0.
